cla16_accum_stage: RTL and testbench
====================================

# cla16_accum_stage

Downstream consumer of the registered 16-bit CLA adder stage in the MAC_512 datapath. Takes the adder's 16-bit result stream under a valid/ready handshake and sums a programmed number of samples into a wide accumulator. It presents the finished sum, the sample count and an overflow flag, and holds them until the next stage accepts them. One accumulation job runs at a time, controlled by a small state machine.

## Interface
- DATA_W, 16, width of each incoming sample (unsigned)
- ACC_W, 25, accumulator width; 512 × 0xFFFF fits exactly
- CNT_W, 10, width of the length and count fields (max job length 1023)

- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  one-cycle job request; honoured only in IDLE
- len_in  input  CNT_W  number of samples in the job; sampled on an accepted start
- clear  input  1  synchronous abort; returns to IDLE and zeroes the accumulator
- in_valid  input  1  upstream sample valid; driven by the adder stage's enable/result path
- in_data  input  DATA_W  upstream sample (adder result)
- in_ready  output  1  high only in ACCUM
- out_valid  output  1  high only in DONE
- out_ready  input  1  downstream accepts the result
- out_sum  output  ACC_W  final sum, modulo 2^ACC_W
- out_cnt  output  CNT_W  number of samples summed (equals the latched length)
- out_ovf  output  1  sticky flag: a carry out of ACC_W occurred during the job
- busy  output  1  high in ACCUM or DONE

## Operation
- States are IDLE, ACCUM and DONE. Reset state is IDLE.
- IDLE:
  - in_ready=0, out_valid=0.
  - On start=1: latch len_in, zero acc/cnt/ovf.
  - If len_in≠0, go to ACCUM. If len_in=0, go straight to DONE with sum 0, cnt 0, ovf 0.
- ACCUM:
  - in_ready=1. A transfer occurs when in_valid & in_ready.
  - On each transfer: acc ← acc + zero-extended in_data, truncated to ACC_W bits. The carry out of bit ACC_W-1 ORs into ovf. cnt ← cnt+1.
  - The transfer that makes cnt equal to the latched length moves the state to DONE.
  - Cycles with in_valid=0 leave all state unchanged. There is no timeout.
- DONE:
  - out_valid=1. out_sum, out_cnt and out_ovf are stable and driven from registers.
  - On out_valid & out_ready, go to IDLE. Outputs keep their values, but out_valid drops.
- start is ignored in ACCUM and DONE, including the cycle of the DONE→IDLE handshake. No job queues.
- clear=1 in any state: next state IDLE, acc/cnt/ovf ← 0, any in-flight sample is discarded. clear has priority over start, over an in_valid transfer and over an out_ready handshake in the same cycle.
- All arithmetic is unsigned. There is no saturation; the sum wraps and out_ovf records that it did.

## Timing
- Reset (rst_n=0, asynchronous): state=IDLE, in_ready=0, out_valid=0, out_sum=0, out_cnt=0, out_ovf=0, busy=0. These take effect immediately, without waiting for a clock edge.
- A start accepted at edge t gives in_ready=1 and busy=1 from t+1.
- Throughput is one sample per cycle when in_valid is held high.
- Latency:
  - If the last sample is transferred at edge k, out_valid=1 from k+1, and out_sum already includes that sample.
  - A job of N samples streamed back-to-back gives out_valid exactly N+1 cycles after the start edge.
- If out_ready is already high when out_valid rises, the handshake completes at the next edge: out_valid is high for exactly one cycle, and IDLE is reached one cycle after DONE.
- Deasserting rst_n in the middle of a job abandons it with no output. The first start after release begins a fresh job.

## Test plan
- Reset/idle: hold rst_n=0 for 3 cycles, then release. All outputs are 0 and in_ready=0. Pulse in_valid with no start → no transfer, and out_sum stays 0.
- Basic job: start with len_in=4, feed 0x0001, 0x0002, 0x0003, 0x0004 back-to-back → out_valid 5 cycles after the start edge, out_sum=10, out_cnt=4, out_ovf=0.
- Backpressure and bubbles:
  - len_in=3, samples 0xFFFF ×3 with an in_valid gap between samples → out_sum=196605. Samples that arrive outside the gaps are each counted once.
  - Hold out_ready=0 for 5 cycles → out_valid and out_sum stay stable throughout, and a start issued in DONE is ignored.
- Full MAC_512 length: len_in=512, 512 samples of 0xFFFF → out_sum=33553920, out_ovf=0.
- Overflow: len_in=1023, 1023 samples of 0xFFFF → out_sum=33487873, out_ovf=1, out_cnt=1023.
- Abort and edge cases:
  - clear asserted after 2 of 4 samples, in the same cycle as an in_valid → IDLE next cycle, acc=0, no out_valid.
  - A following job with len_in=0 → out_valid one cycle after start, with out_sum=0 and out_cnt=0.

Source files
------------

// File: rtl/cla16_accum_stage.sv
// cla16_accum_stage: sums a programmed number of 16-bit adder results into a
// wide accumulator and hands the finished sum, count and overflow flag downstream.
module cla16_accum_stage #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ACC_W  = 25,
    parameter int unsigned CNT_W  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  len_in,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_cnt,
    output logic              out_ovf,
    output logic              busy
);

    localparam int unsigned SUM_W = ACC_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state_q,     state_d;
    logic [ACC_W-1:0]   acc_q,       acc_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic [CNT_W-1:0]   len_q,       len_d;
    logic               ovf_q,       ovf_d;
    logic               in_ready_q,  in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q,      busy_d;

    logic [SUM_W-1:0]   sum_c;
    logic [CNT_W-1:0]   cnt_inc_c;

    // Widened add so the carry out of the accumulator is visible for the overflow flag.
    always_comb begin
        sum_c     = SUM_W'(acc_q) + SUM_W'(in_data);
        cnt_inc_c = cnt_q + CNT_W'(1);
    end

    // Next-state and datapath update; clear overrides every other action.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        ovf_d   = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d   = len_in;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = (len_in != '0) ? ST_ACCUM : ST_DONE;
                end
            end
            ST_ACCUM: begin
                if (in_valid) begin
                    acc_d = sum_c[ACC_W-1:0];
                    ovf_d = ovf_q | sum_c[ACC_W];
                    cnt_d = cnt_inc_c;
                    if (cnt_inc_c == len_q) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (clear) begin
            state_d = ST_IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end
    end

    // Handshake and status flags are registered, decoded from the next state.
    always_comb begin
        in_ready_d  = (state_d == ST_ACCUM);
        out_valid_d = (state_d == ST_DONE);
        busy_d      = (state_d == ST_ACCUM) || (state_d == ST_DONE);
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            len_q       <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_sum   = acc_q;
    assign out_cnt   = cnt_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_cla16_accum_stage.sv
// Directed bench for cla16_accum_stage: table of accumulation jobs plus
// hand-written reset, backpressure, clear and mid-job reset sequences.
module tb_cla16_accum_stage;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ACC_W  = 25;
    localparam int unsigned CNT_W  = 10;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [CNT_W-1:0]  len_in;
    logic              clear;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic [CNT_W-1:0]  out_cnt;
    logic              out_ovf;
    logic              busy;

    cla16_accum_stage #(.DATA_W(DATA_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len_in    (len_in),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cnt   (out_cnt),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unsigned len;
        int unsigned base;
        int unsigned step;
        bit          gap;
        int unsigned exp_sum;
        int unsigned exp_cnt;
        bit          exp_ovf;
    } vec_t;

    vec_t vecs [7];
    int   n_tests;
    int   n_fail;

    task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts a job, streams its samples, checks latency/result, then hands it off.
    task automatic run_job(input vec_t v, input string nm);
        int cyc;
        start  = 1'b1;
        len_in = CNT_W'(v.len);
        tick();
        start  = 1'b0;
        cyc    = 1;
        chk({nm, " busy after start"}, busy, 1);
        chk({nm, " in_ready after start"}, in_ready, (v.len != 0) ? 1 : 0);
        for (int i = 0; i < int'(v.len); i++) begin
            in_valid = 1'b1;
            in_data  = DATA_W'(v.base + i * v.step);
            tick();
            cyc++;
            in_valid = 1'b0;
            in_data  = 16'hDEAD;
            if (v.gap && (i != int'(v.len) - 1)) begin
                tick();
                cyc++;
            end
        end
        while (!out_valid && cyc < int'(v.len) + 12) begin
            tick();
            cyc++;
        end
        chk({nm, " out_valid"}, out_valid, 1);
        if (!v.gap) chk({nm, " latency"}, cyc, v.len + 1);
        chk({nm, " out_sum"}, out_sum, v.exp_sum);
        chk({nm, " out_cnt"}, out_cnt, v.exp_cnt);
        chk({nm, " out_ovf"}, out_ovf, v.exp_ovf);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({nm, " out_valid drop"}, out_valid, 0);
        chk({nm, " busy drop"}, busy, 0);
        chk({nm, " sum held"}, out_sum, v.exp_sum);
    endtask

    initial begin
        vec_t v;
        int   hi_cycles;
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b1;
        start     = 1'b0;
        len_in    = '0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        //              len   base     step     gap  sum        cnt   ovf
        vecs[0] = '{    4,    1,       1,       0,   10,        4,    0};
        vecs[1] = '{    3,    16'hFFFF, 0,      1,   196605,    3,    0};
        vecs[2] = '{    512,  16'hFFFF, 0,      0,   33553920,  512,  0};
        vecs[3] = '{    1023, 16'hFFFF, 0,      0,   33487873,  1023, 1};
        vecs[4] = '{    1,    16'h1234, 0,      0,   4660,      1,    0};
        vecs[5] = '{    0,    0,       0,       0,   0,         0,    0};
        vecs[6] = '{    2,    16'h8000, 16'h7FFF, 0, 98303,     2,    0};

        // Reset: outputs must clear without waiting for a clock edge.
        #2 rst_n = 1'b0;
        #1;
        chk("reset out_valid", out_valid, 0);
        chk("reset in_ready", in_ready, 0);
        chk("reset busy", busy, 0);
        chk("reset out_sum", out_sum, 0);
        chk("reset out_cnt", out_cnt, 0);
        chk("reset out_ovf", out_ovf, 0);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // in_valid without a start transfers nothing.
        in_valid = 1'b1;
        in_data  = 16'h00FF;
        repeat (2) tick();
        in_valid = 1'b0;
        chk("idle in_valid sum", out_sum, 0);
        chk("idle in_valid in_ready", in_ready, 0);
        chk("idle in_valid cnt", out_cnt, 0);

        // Table-driven jobs.
        for (int k = 0; k < 7; k++) begin
            run_job(vecs[k], $sformatf("vec%0d", k));
        end

        // Backpressure: result holds for 5 cycles, start in DONE ignored.
        v = '{2, 100, 1, 0, 201, 2, 0};
        start  = 1'b1;
        len_in = 10'd2;
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 16'd100;
        tick();
        in_data  = 16'd101;
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            start  = (c == 2);
            len_in = 10'd5;
            chk($sformatf("bp out_valid c%0d", c), out_valid, 1);
            chk($sformatf("bp out_sum c%0d", c), out_sum, v.exp_sum);
            tick();
        end
        start = 1'b0;
        chk("bp in_ready after ignored start", in_ready, 0);
        // Start during the handshake cycle is also ignored.
        start     = 1'b1;
        out_ready = 1'b1;
        tick();
        start     = 1'b0;
        out_ready = 1'b0;
        chk("bp handshake out_valid", out_valid, 0);
        chk("bp handshake start ignored", busy, 0);
        tick();
        chk("bp still idle", in_ready, 0);

        // out_ready held high in advance: out_valid lasts exactly one cycle.
        out_ready = 1'b1;
        start     = 1'b1;
        len_in    = 10'd1;
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 16'd7;
        tick();
        in_valid  = 1'b0;
        hi_cycles = 0;
        for (int c = 0; c < 4; c++) begin
            if (out_valid) hi_cycles++;
            tick();
        end
        out_ready = 1'b0;
        chk("early ready valid cycles", hi_cycles, 1);
        chk("early ready sum", out_sum, 7);

        // Clear after 2 of 4 samples, coinciding with a valid sample.
        start  = 1'b1;
        len_in = 10'd4;
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 16'd50;
        repeat (2) tick();
        clear = 1'b1;
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        chk("clear busy", busy, 0);
        chk("clear in_ready", in_ready, 0);
        chk("clear out_sum", out_sum, 0);
        chk("clear out_cnt", out_cnt, 0);
        hi_cycles = 0;
        for (int c = 0; c < 4; c++) begin
            if (out_valid) hi_cycles++;
            tick();
        end
        chk("clear no out_valid", hi_cycles, 0);
        run_job(vecs[5], "post-clear len0");

        // Reset in the middle of a job abandons it immediately.
        start  = 1'b1;
        len_in = 10'd4;
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 16'd9;
        tick();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midreset busy", busy, 0);
        chk("midreset in_ready", in_ready, 0);
        chk("midreset out_sum", out_sum, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("midreset no out_valid", out_valid, 0);
        run_job(vecs[0], "post-reset job");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
